dac_osc_sequencer: RTL and testbench
====================================

Name: dac_osc_sequencer

Overview:
Digital controller that sequences the 8-bit resistor-ladder DAC of the oscillator macro. Host pins write four config registers. A prescaled phase accumulator then generates DC, sawtooth, triangle or square codes on dac_code. On stop, the output ramps down gracefully to zero before going idle. It sits between the top-level pin interface (ui_in/uio_in) and the analog ladder inputs.

Parameters:
ACC_W, 16, phase accumulator width (≥ 10); dac_code = acc[ACC_W-1 -: 8]
DIV_W, 8, prescaler width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes waveform generation
cfg_wr  in  1  asynchronous write strobe from pin; rising edge commits write
cfg_addr  in  2  register address (0 CTRL, 1 STEP, 2 DIV, 3 LEVEL)
cfg_data  in  8  write data; must be stable from cfg_wr rise until 3 clk later
dac_code  out  8  ladder drive code
dac_upd  out  1  one-cycle pulse when dac_code changes
sync_out  out  1  one-cycle pulse on accumulator wrap
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all registers, outputs and the accumulator are 0; state IDLE.
- Write path:
  - cfg_wr passes through a 2-flop synchronizer plus rising-edge detect.
  - On a detected edge, cfg_data is written to the register at cfg_addr.
  - The new value is visible 3 cycles after cfg_wr rises.
  - Writes are accepted regardless of ena.
- CTRL register: [1:0] mode (0 DC, 1 SAW, 2 TRI, 3 SQR); [2] run; [7:3] reserved, read as 0 internally.
- Tick: prescaler counts 0..DIV, then asserts tick and returns to 0. DIV=0 gives a tick every cycle. Prescaler counts only in RUN/DRAIN with ena=1.
- FSM:
  - IDLE: dac_code=0. If run=1, go to PRIME.
  - PRIME (1 cycle): acc=0, prescaler=0; go to RUN.
  - RUN: each tick, acc += STEP (zero-extended, modulo 2^ACC_W). A carry-out pulses sync_out in the same cycle the acc register updates. If run=0, go to DRAIN.
  - DRAIN: each tick, dac_code -= max(STEP,1), saturating at 0. At 0, go to IDLE. run=1 during DRAIN is ignored until IDLE is reached.
- Code in RUN, registered so it updates the cycle after acc (let p = acc[ACC_W-1 -: 8]):
  - DC: LEVEL.
  - SAW: p.
  - TRI: {acc[ACC_W-2 -: 8]} when acc MSB=0, else its bitwise inverse.
  - SQR: LEVEL when acc MSB=1, else 0.
- Config changes in RUN: mode changes take effect on the next code update. STEP/DIV changes take effect on the next tick; the prescaler is not reset.
- ena=0: prescaler, acc, FSM and dac_code hold; sync_out and dac_upd stay 0.
- Reset asserted mid-operation: immediate return to reset values. No drain on reset.

Optional Feature:
DAC_OSC_DITHER_EN
- Defined: an 8-bit Galois LFSR (taps 8,6,5,4; seed 0xB8 on reset) advances each tick. In SAW/TRI, the generated code adds lfsr[0], saturating at 255. DC, SQR and DRAIN are unaffected.
- Undefined: no LFSR logic exists; output equals the formulas above exactly.

Decomposition:
- Package dac_osc_pkg:
  - mode enum (MODE_DC, MODE_SAW, MODE_TRI, MODE_SQR)
  - state enum (ST_IDLE, ST_PRIME, ST_RUN, ST_DRAIN)
  - register address constants (ADDR_CTRL..ADDR_LEVEL)
  - CTRL bit positions
  - LFSR seed/taps
- Sub-module dac_osc_cfg_sync: synchronizer, edge detect and the register file. FSM, prescaler and datapath stay in the top.

Test Plan:
- Reset then idle: pulse rst_n low mid-RUN -> dac_code=0, busy=0, sync_out=0 within the same cycle (async).
- Sawtooth: STEP=0x80, DIV=0, mode SAW, run=1 -> dac_code increments by 1 every 2 cycles; sync_out pulses every 512 cycles; code 0xFF→0x00 at the wrap.
- Prescaler and ena: STEP=0x80, DIV=3 -> acc advances every 4 cycles. Drop ena for 10 cycles -> dac_code, acc and prescaler frozen; resume -> continues from the same value.
- Triangle: STEP=0x40, DIV=0 (1024-cycle period) -> code rises 0→0xFF then falls; TRI peak at acc=0x7FC0→0x8000 boundary; no repeated or skipped value beyond step size.
- Drain: SAW running at code 0x90, STEP=0x20, write run=0 -> state DRAIN; code decreases by 0x20 per tick to 0 (saturating, no underflow); busy drops the cycle after 0. A run=1 write during drain restarts only after IDLE.
- Write sync: cfg_wr rise with addr=3, data=0xA5 in DC mode with run=1 -> dac_code=0xA5 with dac_upd pulse exactly 4 cycles after the rise (3-cycle write plus registered output). A second cfg_wr held high does not cause a repeat write.

Source files
------------

// File: rtl/dac_osc_pkg.sv
// ---------------------------------------------------------------------------
// dac_osc_pkg
// Shared types and constants for the oscillator DAC sequencer:
//   mode_e   - waveform selection held in CTRL[1:0]
//   state_e  - sequencer FSM states
//   ADDR_*   - host register addresses
//   CTRL_*   - CTRL bit positions
//   LFSR_*   - dither LFSR seed and Galois tap mask (x^8+x^6+x^5+x^4+1)
// ---------------------------------------------------------------------------
package dac_osc_pkg;

  typedef enum logic [1:0] {
    MODE_DC  = 2'd0,
    MODE_SAW = 2'd1,
    MODE_TRI = 2'd2,
    MODE_SQR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_STEP  = 2'd1;
  localparam logic [1:0] ADDR_DIV   = 2'd2;
  localparam logic [1:0] ADDR_LEVEL = 2'd3;

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_MSB = 1;
  localparam int CTRL_RUN_BIT  = 2;

  localparam logic [7:0] LFSR_SEED = 8'hB8;
  // Right-shifting Galois form: bits 7,5,4,3 correspond to taps 8,6,5,4.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/dac_osc_cfg_sync.sv
// ---------------------------------------------------------------------------
// dac_osc_cfg_sync
// Brings the asynchronous host write strobe into the clk domain and holds the
// four configuration registers.
//   clk, rst_n         clock, asynchronous active-low reset
//   cfg_wr             asynchronous write strobe (rising edge commits)
//   cfg_addr, cfg_data register address and data (stable across the sync)
//   ctrl_mode_reg      CTRL[1:0] waveform mode
//   ctrl_run_reg       CTRL[2] run request
//   step_reg           accumulator increment
//   div_reg            prescaler terminal count
//   level_reg          DC / square amplitude
// A register is written on the third clk edge after cfg_wr rises: two edges
// through the synchronizer, one for the edge detect to be registered into
// the register file. CTRL[7:3] are not stored.
// ---------------------------------------------------------------------------
module dac_osc_cfg_sync
  import dac_osc_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_data,
  output mode_e            ctrl_mode_reg,
  output logic             ctrl_run_reg,
  output logic [7:0]       step_reg,
  output logic [DIV_W-1:0] div_reg,
  output logic [7:0]       level_reg
);

  logic wr_meta_reg;
  logic wr_sync_reg;
  logic wr_prev_reg;
  logic wr_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_meta_reg <= 1'b0;
      wr_sync_reg <= 1'b0;
      wr_prev_reg <= 1'b0;
    end else begin
      wr_meta_reg <= cfg_wr;
      wr_sync_reg <= wr_meta_reg;
      wr_prev_reg <= wr_sync_reg;
    end
  end

  // A strobe held high yields exactly one write.
  assign wr_edge = wr_sync_reg & ~wr_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_mode_reg <= MODE_DC;
      ctrl_run_reg  <= 1'b0;
      step_reg      <= 8'h00;
      div_reg       <= '0;
      level_reg     <= 8'h00;
    end else if (wr_edge) begin
      case (cfg_addr)
        ADDR_CTRL: begin
          ctrl_mode_reg <= mode_e'(cfg_data[CTRL_MODE_MSB:CTRL_MODE_LSB]);
          ctrl_run_reg  <= cfg_data[CTRL_RUN_BIT];
        end
        ADDR_STEP:  step_reg  <= cfg_data;
        ADDR_DIV:   div_reg   <= DIV_W'(cfg_data);
        default:    level_reg <= cfg_data;
      endcase
    end
  end

endmodule

// File: rtl/dac_osc_sequencer.sv
// ---------------------------------------------------------------------------
// dac_osc_sequencer
// Sequences the 8-bit resistor-ladder DAC: a prescaled phase accumulator
// produces DC, sawtooth, triangle or square codes; on stop the code ramps
// down to zero before the sequencer goes idle.
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          global enable; low freezes the whole generator
//   cfg_wr       asynchronous host write strobe
//   cfg_addr     register address (CTRL, STEP, DIV, LEVEL)
//   cfg_data     register write data
//   dac_code     ladder drive code (registered)
//   dac_upd      one-cycle pulse whenever dac_code changes
//   sync_out     one-cycle pulse on accumulator wrap
//   busy         high whenever the FSM is not idle
// Optional build macro: DAC_OSC_DITHER_EN adds a 1-LSB LFSR dither to the
// sawtooth and triangle codes.
// ---------------------------------------------------------------------------
module dac_osc_sequencer
  import dac_osc_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int DIV_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic [7:0] dac_code,
  output logic       dac_upd,
  output logic       sync_out,
  output logic       busy
);

  mode_e            mode;
  logic             run;
  logic [7:0]       step;
  logic [DIV_W-1:0] div;
  logic [7:0]       level;

  dac_osc_cfg_sync #(.DIV_W(DIV_W)) u_cfg (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_wr       (cfg_wr),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .ctrl_mode_reg(mode),
    .ctrl_run_reg (run),
    .step_reg     (step),
    .div_reg      (div),
    .level_reg    (level)
  );

  state_e           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [DIV_W-1:0] presc_reg, presc_next;
  logic [7:0]       code_reg, code_next;
  logic             upd_reg, sync_reg, sync_next;

  logic             tick;
  logic [ACC_W:0]   acc_sum;
  logic [7:0]       phase;
  logic [7:0]       tri_raw;
  logic             acc_msb;
  logic [7:0]       wave_code;
  logic [7:0]       gen_code;
  logic [7:0]       drain_dec;
  logic [7:0]       drain_code;

  // '>=' rather than '==' so that lowering DIV below the current count
  // ticks immediately instead of wrapping the whole prescaler range.
  assign tick = ena && (state_reg == ST_RUN || state_reg == ST_DRAIN) &&
                (presc_reg >= div);

  assign acc_sum = {1'b0, acc_reg} + {{(ACC_W-7){1'b0}}, step};
  assign phase   = acc_reg[ACC_W-1 -: 8];
  assign tri_raw = acc_reg[ACC_W-2 -: 8];
  assign acc_msb = acc_reg[ACC_W-1];

  always_comb begin
    wave_code = 8'h00;
    case (mode)
      MODE_DC:  wave_code = level;
      MODE_SAW: wave_code = phase;
      MODE_TRI: wave_code = acc_msb ? ~tri_raw : tri_raw;
      default:  wave_code = acc_msb ? level : 8'h00;
    endcase
  end

`ifdef DAC_OSC_DITHER_EN
  logic [7:0] lfsr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= LFSR_SEED;
    end else if (tick) begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  always_comb begin
    gen_code = wave_code;
    if ((mode == MODE_SAW || mode == MODE_TRI) && lfsr_reg[0] &&
        wave_code != 8'hFF) begin
      gen_code = wave_code + 8'd1;
    end
  end
`else
  assign gen_code = wave_code;
`endif

  // A zero STEP would stall the ramp-down forever, so drain by at least 1.
  assign drain_dec  = (step == 8'h00) ? 8'd1 : step;
  assign drain_code = (code_reg <= drain_dec) ? 8'h00 : code_reg - drain_dec;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    presc_next = presc_reg;
    code_next  = code_reg;
    sync_next  = 1'b0;
    if (ena) begin
      case (state_reg)
        ST_IDLE: begin
          code_next = 8'h00;
          if (run) state_next = ST_PRIME;
        end
        ST_PRIME: begin
          acc_next   = '0;
          presc_next = '0;
          state_next = ST_RUN;
        end
        ST_RUN: begin
          presc_next = tick ? '0 : presc_reg + 1'b1;
          if (tick) begin
            acc_next  = acc_sum[ACC_W-1:0];
            sync_next = acc_sum[ACC_W];
          end
          // Code follows the accumulator register one cycle later.
          code_next = gen_code;
          if (!run) state_next = ST_DRAIN;
        end
        default: begin
          presc_next = tick ? '0 : presc_reg + 1'b1;
          if (code_reg == 8'h00) begin
            state_next = ST_IDLE;
          end else if (tick) begin
            code_next = drain_code;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      presc_reg <= '0;
      code_reg  <= 8'h00;
      upd_reg   <= 1'b0;
      sync_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      presc_reg <= presc_next;
      code_reg  <= code_next;
      upd_reg   <= (code_next != code_reg);
      sync_reg  <= sync_next;
    end
  end

  assign dac_code = code_reg;
  assign dac_upd  = upd_reg;
  assign sync_out = sync_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dac_osc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dac_osc_sequencer
// Directed bench for dac_osc_sequencer (default build, no dither). Cycle
// positions are counted from the first clk edge after which busy is high
// (the IDLE->PRIME edge, called B below); expected codes are derived by hand
// from that anchor.
// ---------------------------------------------------------------------------
module tb_dac_osc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cfg_wr;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [7:0] dac_code;
  logic       dac_upd;
  logic       sync_out;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int m = 0;

  dac_osc_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .cfg_wr  (cfg_wr),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .dac_code(dac_code),
    .dac_upd (dac_upd),
    .sync_out(sync_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; the strobe is left high.
  task automatic wr_begin(input logic [1:0] a, input logic [7:0] d);
    cfg_addr = a;
    cfg_data = d;
    cfg_wr   = 1'b1;
    $display("write addr=%0d data=0x%02h", a, d);
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] d);
    wr_begin(a, d);
    repeat (4) @(negedge clk);
    cfg_wr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    cfg_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the negedge just after edge B and zeroes the cycle counter.
  task automatic wait_busy();
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (busy) found = 1;
    end
    if (!found) check("busy_timeout", 32'd0, 32'd1);
    m = 0;
  endtask

  task automatic adv_to(input int target);
    while (m < target) begin
      @(negedge clk);
      m++;
    end
  endtask

  initial begin
    int bad, jumps, syncs, sync_at, exp_i, a, t, prev, chg;
    logic [7:0] c513, c514, c516, c258, c1025;

    // ---------------- reset values ----------------
    rst_n = 1'b0; ena = 1'b1; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_data = 8'h00;
    @(negedge clk);
    check("rst_code", dac_code, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_sync", sync_out, 1'b0);
    check("rst_upd", dac_upd, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- write synchronizer ----------------
    write(2'd0, 8'h04);                       // DC, run
    check("wsync_busy", busy, 1'b1);
    check("wsync_code0", dac_code, 8'h00);
    wr_begin(2'd3, 8'hA5);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("wsync_early", dac_code, 8'h00);
    end
    @(negedge clk);
    check("wsync_code", dac_code, 8'hA5);
    check("wsync_upd", dac_upd, 1'b1);
    @(negedge clk);
    check("wsync_upd_pulse", dac_upd, 1'b0);
    cfg_data = 8'h3C;                         // strobe still high
    chg = 0;
    repeat (8) begin
      @(negedge clk);
      if (dac_upd) chg++;
    end
    check("wsync_norepeat_upd", chg, 0);
    check("wsync_norepeat_code", dac_code, 8'hA5);
    cfg_wr = 1'b0;

    // ---------------- sawtooth ----------------
    do_reset();
    write(2'd1, 8'h80);
    wr_begin(2'd0, 8'h05);
    wait_busy();
    cfg_wr = 1'b0;
    bad = 0; syncs = 0; sync_at = 0; c513 = 8'h00; c514 = 8'h11;
    while (m < 520) begin
      @(negedge clk);
      m++;
      exp_i = (m >= 2) ? (((m - 2) >> 1) & 255) : 0;
      if (dac_code !== exp_i[7:0]) bad++;
      if (sync_out) begin syncs++; sync_at = m; end
      if (m == 513) c513 = dac_code;
      if (m == 514) c514 = dac_code;
    end
    check("saw_sequence", bad, 0);
    check("saw_sync_count", syncs, 1);
    check("saw_sync_pos", sync_at, 513);
    check("saw_code_top", c513, 8'hFF);
    check("saw_code_wrap", c514, 8'h00);

    // ---------------- prescaler and ena ----------------
    do_reset();
    write(2'd1, 8'h80);
    write(2'd2, 8'h03);
    wr_begin(2'd0, 8'h05);
    wait_busy();
    cfg_wr = 1'b0;
    adv_to(9);  check("div_m9", dac_code, 8'h00);
    adv_to(10); check("div_m10", dac_code, 8'h01);
    check("div_m10_upd", dac_upd, 1'b1);
    adv_to(18); check("div_m18", dac_code, 8'h02);
    adv_to(20); check("div_m20", dac_code, 8'h02);
    ena = 1'b0;
    chg = 0;
    while (m < 30) begin
      @(negedge clk);
      m++;
      if (dac_upd || sync_out || dac_code !== 8'h02) chg++;
    end
    check("ena_frozen", chg, 0);
    ena = 1'b1;
    adv_to(35); check("ena_resume_m35", dac_code, 8'h02);
    adv_to(36); check("ena_resume_m36", dac_code, 8'h03);

    // ---------------- triangle ----------------
    do_reset();
    write(2'd1, 8'h40);
    wr_begin(2'd0, 8'h06);
    wait_busy();
    cfg_wr = 1'b0;
    bad = 0; jumps = 0; prev = 0;
    c258 = 8'h00; c516 = 8'h00; c1025 = 8'h11; c513 = 8'h00; c514 = 8'h00;
    while (m < 1100) begin
      @(negedge clk);
      m++;
      if (m >= 2) begin
        a = ((m - 2) * 64) & 16'hFFFF;
        t = (a >> 7) & 255;
        exp_i = (a & 16'h8000) ? ((~t) & 255) : t;
      end else begin
        exp_i = 0;
      end
      if (dac_code !== exp_i[7:0]) bad++;
      if (int'(dac_code) - prev > 1 || prev - int'(dac_code) > 1) jumps++;
      prev = int'(dac_code);
      if (m == 258)  c258  = dac_code;
      if (m == 513)  c513  = dac_code;
      if (m == 514)  c514  = dac_code;
      if (m == 516)  c516  = dac_code;
      if (m == 1025) c1025 = dac_code;
    end
    check("tri_sequence", bad, 0);
    check("tri_no_skip", jumps, 0);
    check("tri_mid_rise", c258, 8'h80);
    check("tri_peak_7fc0", c513, 8'hFF);
    check("tri_peak_8000", c514, 8'hFF);
    check("tri_falling", c516, 8'hFE);
    check("tri_bottom", c1025, 8'h00);

    // ---------------- drain ----------------
    do_reset();
    write(2'd1, 8'h20);
    wr_begin(2'd0, 8'h05);
    wait_busy();
    cfg_wr = 1'b0;
    adv_to(1150); check("drain_pre", dac_code, 8'h8F);
    wr_begin(2'd0, 8'h01);                    // SAW, run=0
    adv_to(1154);
    check("drain_start_code", dac_code, 8'h90);
    check("drain_start_busy", busy, 1'b1);
    cfg_wr = 1'b0;
    adv_to(1155); check("drain_d1", dac_code, 8'h70);
    wr_begin(2'd0, 8'h05);                    // run=1 while draining
    adv_to(1156); check("drain_d2", dac_code, 8'h50);
    adv_to(1157); check("drain_d3", dac_code, 8'h30);
    adv_to(1158); check("drain_d4", dac_code, 8'h10);
    adv_to(1159); check("drain_zero", dac_code, 8'h00);
    check("drain_zero_busy", busy, 1'b1);
    cfg_wr = 1'b0;
    adv_to(1160); check("drain_idle_busy", busy, 1'b0);
    check("drain_idle_code", dac_code, 8'h00);
    adv_to(1161); check("drain_restart_busy", busy, 1'b1);

    // ---------------- asynchronous reset mid-run ----------------
    adv_to(1161 + 42);
    check("restart_code", dac_code, 8'h05);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_code", dac_code, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_sync", sync_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
